// File: rtl/segment_step_generator.sv
// Segment step generator: pops 4-byte motion records from the segment FIFO and
// plays each one out as a burst of step pulses with direction levels on up
// to four motor channels.
module segment_step_generator #(
    parameter int WORD_SIZE    = 8,
    parameter int RECORD_WORDS = 4,
    parameter int NUM_MOTORS   = 4,
    parameter int PRESCALE     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [WORD_SIZE-1:0]  fifo_data,
    output logic                  fifo_read_en,
    output logic [NUM_MOTORS-1:0] step,
    output logic [NUM_MOTORS-1:0] dir,
    output logic                  busy,
    output logic                  segment_done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = $clog2(RECORD_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_LOW,
        S_HIGH
    } state_t;

    state_t state, state_nxt;

    // rec[0] = {dir, mask}, rec[1]/rec[2] = step count lo/hi, rec[3] = half-period
    logic [RECORD_WORDS-1:0][WORD_SIZE-1:0] rec;
    logic [IW-1:0]                          idx;
    logic                                   pending;    // a pop is in flight
    logic [PW-1:0]                          presc;
    logic [WORD_SIZE-1:0]                   hcnt;
    logic [15:0]                            count;

    logic [NUM_MOTORS-1:0] mask;
    logic [WORD_SIZE-1:0]  h_last;
    logic                  presc_last;
    logic                  phase_end;
    logic                  rec_zero;

    // Record decode and phase timing: a half-period of H=0 is treated as H=1
    always_comb begin
        mask       = rec[0][NUM_MOTORS-1:0];
        h_last     = (rec[3] == '0) ? '0 : rec[3] - WORD_SIZE'(1);
        presc_last = (presc == PW'(PRESCALE - 1));
        phase_end  = presc_last && (hcnt == h_last);
        rec_zero   = ({rec[2], rec[1]} == 16'd0) || (mask == '0);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state and output decode
    always_comb begin
        state_nxt    = state;
        fifo_read_en = 1'b0;
        step         = '0;
        busy         = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (enable && !fifo_empty) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                fifo_read_en = !pending && !fifo_empty;
                if (pending && idx == IW'(RECORD_WORDS - 1)) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                state_nxt = rec_zero ? S_IDLE : S_LOW;
            end
            S_LOW: begin
                if (phase_end) state_nxt = S_HIGH;
            end
            S_HIGH: begin
                step = mask;
                if (phase_end) state_nxt = (count == 16'd1) ? S_IDLE : S_LOW;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: byte capture, phase timer, step counter, dir and done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rec          <= '0;
            idx          <= '0;
            pending      <= 1'b0;
            presc        <= '0;
            hcnt         <= '0;
            count        <= '0;
            dir          <= '0;
            segment_done <= 1'b0;
        end else begin
            segment_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    idx     <= '0;
                    pending <= 1'b0;
                end
                S_FETCH: begin
                    if (pending) begin
                        rec[idx] <= fifo_data;
                        idx      <= idx + IW'(1);
                        pending  <= 1'b0;
                    end else if (fifo_read_en) begin
                        pending <= 1'b1;
                    end
                end
                S_LOAD: begin
                    dir   <= rec[0][WORD_SIZE-1:WORD_SIZE-NUM_MOTORS];
                    presc <= '0;
                    hcnt  <= '0;
                    count <= {rec[2], rec[1]};
                    if (rec_zero) segment_done <= 1'b1;
                end
                S_LOW, S_HIGH: begin
                    if (phase_end) begin
                        presc <= '0;
                        hcnt  <= '0;
                        if (state == S_HIGH) begin
                            count <= count - 16'd1;
                            if (count == 16'd1) segment_done <= 1'b1;
                        end
                    end else if (presc_last) begin
                        presc <= '0;
                        hcnt  <= hcnt + WORD_SIZE'(1);
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_segment_step_generator.sv
// Scoreboard bench for segment_step_generator (PRESCALE=2). Stimulus pushes
// record bytes into a FIFO model and the expected per-record result into a
// queue; the monitor measures each segment and compares on segment_done.
module tb_segment_step_generator;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       fifo_empty;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_read_en;
    logic [3:0] step;
    logic [3:0] dir;
    logic       busy;
    logic       segment_done;

    segment_step_generator #(.PRESCALE(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_read_en (fifo_read_en),
        .step         (step),
        .dir          (dir),
        .busy         (busy),
        .segment_done (segment_done)
    );

    initial forever #5 clk = ~clk;

    // FIFO model
    logic [7:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    initial forever begin
        @(posedge clk);
        if (fifo_read_en) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    typedef struct {
        logic [3:0]       dir;
        logic [3:0][15:0] pulses;
        logic [3:0][15:0] hi;
        int               hrun;
        int               len;     // cycles from last fifo pop to done
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   fin = 1'b0;

    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr++;
    endtask

    task automatic push_rec(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
        push_byte(b0); push_byte(b1); push_byte(b2); push_byte(b3);
    endtask

    // Hand-computed expectations: pulses/high cycles apply to motors in mask
    task automatic push_exp(input logic [3:0] d, input logic [3:0] m, input int npul,
                            input int nhi, input int hrun, input int len);
        exp_t e;
        e.dir = d;
        for (int i = 0; i < 4; i++) begin
            e.pulses[i] = m[i] ? 16'(npul) : 16'd0;
            e.hi[i]     = m[i] ? 16'(nhi)  : 16'd0;
        end
        e.hrun = hrun;
        e.len  = len;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int max_cyc);
        int n = 0;
        while (!segment_done && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
    endtask

    // Stimulus
    initial begin
        int n;
        reset  = 1'b1;
        enable = 1'b1;
        // Reset held with a record waiting; then 35 03 00 02: dir 3, mask 5, N=3, HP=4
        push_exp(4'h3, 4'h5, 3, 12, 4, 27);
        push_rec(8'h35, 8'h03, 8'h00, 8'h02);
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        wait_done(200);

        // Mask zero: no pulses, dir F, done 3 cycles after last pop
        push_exp(4'hF, 4'h0, 0, 0, 0, 3);
        push_rec(8'hF0, 8'h05, 8'h00, 8'h01);
        wait_done(100);

        // Starvation mid-record: 9A 02 00 00 -> dir 9, mask A, N=2, H=0->1, HP=2
        push_exp(4'h9, 4'hA, 2, 4, 2, 11);
        push_byte(8'h9A); push_byte(8'h02);
        repeat (50) @(posedge clk);
        #1;
        push_byte(8'h00); push_byte(8'h00);
        wait_done(200);

        // Two queued records, enable dropped mid-segment of the first
        push_exp(4'h6, 4'hF, 2, 12, 6, 27);
        push_rec(8'h6F, 8'h02, 8'h00, 8'h03);
        push_exp(4'hC, 4'h1, 257, 514, 2, 1031);
        push_rec(8'hC1, 8'h01, 8'h01, 8'h01);
        n = 0;
        while (!busy && n < 50) begin @(posedge clk); #1; n++; end
        repeat (15) @(posedge clk);
        #1 enable = 1'b0;
        wait_done(200);
        repeat (20) @(posedge clk);
        #1 enable = 1'b1;
        wait_done(2000);

        // Async reset while stepping: record is dropped with no done
        push_rec(8'h3F, 8'h04, 8'h00, 8'h02);
        n = 0;
        while (step == 4'h0 && n < 200) begin @(posedge clk); #1; n++; end
        @(posedge clk);
        #2 reset = 1'b1;
        // Next record A5 01 00 01 -> dir A, mask 5, N=1, HP=2
        push_exp(4'hA, 4'h5, 1, 2, 2, 7);
        push_rec(8'hA5, 8'h01, 8'h00, 8'h01);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        wait_done(200);

        repeat (5) @(posedge clk);
        fin = 1'b1;
    end

    // Monitor / scoreboard
    initial begin
        int         cyc = 0;
        int         last_rd = 0;
        int         rel_cnt = 0;
        bit         want_rd = 1'b0;
        bit         prev_reset = 1'b1;
        bit         prev_busy = 1'b0;
        bit         prev_en = 1'b0;
        logic [3:0] prev_step = 4'h0;
        int         run [4];
        logic [3:0][15:0] pulses;
        logic [3:0][15:0] hi;
        exp_t       e;
        for (int i = 0; i < 4; i++) run[i] = 0;
        pulses = '0;
        hi     = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                checks++;
                if (fifo_read_en || step != 4'h0 || dir != 4'h0 || busy || segment_done) begin
                    errors++;
                    $display("FAIL reset_outputs: rd=%b step=%b dir=%b busy=%b done=%b, all required 0",
                             fifo_read_en, step, dir, busy, segment_done);
                end
                for (int i = 0; i < 4; i++) run[i] = 0;
                pulses     = '0;
                hi         = '0;
                prev_step  = 4'h0;
                prev_busy  = 1'b0;
                prev_reset = 1'b1;
                want_rd    = 1'b0;
            end else begin
                if (prev_reset) begin
                    rel_cnt = 0;
                    want_rd = !fifo_empty && enable;
                end else begin
                    rel_cnt++;
                end
                prev_reset = 1'b0;

                if (fifo_read_en) begin
                    checks++;
                    if (fifo_empty) begin
                        errors++;
                        $display("FAIL read_while_empty: fifo_read_en=1 with fifo_empty=1 at cycle %0d", cyc);
                    end
                    last_rd = cyc;
                end

                if (want_rd && (fifo_read_en || rel_cnt > 2)) begin
                    checks++;
                    if (rel_cnt > 2 || !fifo_read_en) begin
                        errors++;
                        $display("FAIL first_read_en: %0d cycles after reset release, required <= 2", rel_cnt);
                    end
                    want_rd = 1'b0;
                end

                if (busy && !prev_busy) begin
                    checks++;
                    if (!prev_en) begin
                        errors++;
                        $display("FAIL start_enable: record started with enable=%b, required 1", prev_en);
                    end
                end

                for (int i = 0; i < 4; i++) begin
                    if (step[i]) begin
                        hi[i] = hi[i] + 16'd1;
                        run[i]++;
                        if (!prev_step[i]) pulses[i] = pulses[i] + 16'd1;
                    end else if (prev_step[i]) begin
                        if (exp_q.size() > 0) begin
                            checks++;
                            if (run[i] != exp_q[0].hrun) begin
                                errors++;
                                $display("FAIL step_high_width m%0d: got %0d cycles, required %0d",
                                         i, run[i], exp_q[0].hrun);
                            end
                        end
                        run[i] = 0;
                    end
                end
                prev_step = step;

                if (segment_done) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_done: segment_done with no record pending at cycle %0d", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (dir != e.dir) begin
                            errors++;
                            $display("FAIL dir: got %h required %h", dir, e.dir);
                        end
                        checks++;
                        if (pulses != e.pulses) begin
                            errors++;
                            $display("FAIL pulse_count: got %h required %h", pulses, e.pulses);
                        end
                        checks++;
                        if (hi != e.hi) begin
                            errors++;
                            $display("FAIL high_cycles: got %h required %h", hi, e.hi);
                        end
                        checks++;
                        if (cyc - last_rd != e.len) begin
                            errors++;
                            $display("FAIL segment_len: got %0d required %0d", cyc - last_rd, e.len);
                        end
                    end
                    pulses = '0;
                    hi     = '0;
                end
                prev_busy = busy;
            end
            prev_en = enable;

            if (fin || cyc > 20000) begin
                checks++;
                if (!fin) begin
                    errors++;
                    $display("FAIL timeout: stimulus did not complete within %0d cycles", cyc);
                end
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL records_outstanding: %0d records never completed, required 0", exp_q.size());
                end
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end

endmodule
